// File: rtl/fifo_sel_pkg.sv
// Shared constants and FSM encoding for the FIFO select path (arbiter and read side).
package fifo_sel_pkg;

    localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;
    localparam int         SEL_VALID_BIT   = 7;
    localparam int         SEL_IDX_W       = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_sel_rd_if.sv
// Registered valid/ready word stream leaving the FIFO select read side.
interface fifo_sel_rd_if
    import fifo_sel_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_eop;
    logic [SEL_IDX_W-1:0] out_port;

    modport master (
        output out_valid, out_data, out_eop, out_port,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_eop, out_port,
        output out_ready
    );
endinterface

// File: rtl/fifo_rd_oreg.sv
// Single-entry valid/ready output register holding one word with its eop flag and source port.
module fifo_rd_oreg
    import fifo_sel_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 glb_clk,
    input  logic                 glb_areset_n,
    input  logic                 load,
    input  logic [DATA_W-1:0]    load_data,
    input  logic                 load_eop,
    input  logic [SEL_IDX_W-1:0] load_port,
    output logic                 free,
    fifo_sel_rd_if.master        ob
);

    logic                 valid_q;
    logic                 eop_q;
    logic [DATA_W-1:0]    data_q;
    logic [SEL_IDX_W-1:0] port_q;

    // Free when empty or the held word leaves this cycle, so pop and accept overlap.
    assign free = !valid_q || ob.out_ready;

    always_ff @(posedge glb_clk) begin
        if (!glb_areset_n) begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            port_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            eop_q   <= load_eop;
            data_q  <= load_data;
            port_q  <= load_port;
        end else if (ob.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign ob.out_valid = valid_q;
    assign ob.out_data  = data_q;
    assign ob.out_eop   = eop_q;
    assign ob.out_port  = port_q;

endmodule

// File: rtl/fifo_sel_rd.sv
// Read side of the FIFO select path: pops one packet from the port chosen by the arbiter code.
module fifo_sel_rd
    import fifo_sel_pkg::*;
#(
    parameter int PORT_NUM    = 14,
    parameter int DATA_W      = 32,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                       glb_clk,
    input  logic                       glb_areset_n,
    input  logic [7:0]                 fifo_sel_res_final,
    input  logic [PORT_NUM-1:0]        fifo_empty,
    input  logic [PORT_NUM*DATA_W-1:0] fifo_dout,
    input  logic [PORT_NUM-1:0]        fifo_eop,
    output logic [PORT_NUM-1:0]        fifo_rd_en,
    fifo_sel_rd_if.master              ob,
    output logic                       pkt_done,
    output logic                       pkt_trunc,
    output logic                       sel_err
);

    localparam int                   CNT_W    = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [SEL_IDX_W-1:0] PORT_LIM = SEL_IDX_W'(PORT_NUM);

    rd_state_t            state, state_nxt;
    logic [SEL_IDX_W-1:0] cur_port;
    logic [CNT_W-1:0]     word_cnt;
    logic                 head_empty, head_eop;
    logic [DATA_W-1:0]    head_data;
    logic                 oreg_free, pop, last;

    logic                 sel_vld;
    logic [SEL_IDX_W-1:0] sel_idx;

    assign sel_vld = fifo_sel_res_final[SEL_VALID_BIT];
    assign sel_idx = fifo_sel_res_final[SEL_IDX_W-1:0];

    always_comb begin
        head_empty = 1'b1;
        head_eop   = 1'b0;
        head_data  = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            if (cur_port == SEL_IDX_W'(i)) begin
                head_empty = fifo_empty[i];
                head_eop   = fifo_eop[i];
                head_data  = fifo_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        last       = 1'b0;
        fifo_rd_en = '0;
        case (state)
            ST_IDLE: begin
                if (sel_vld && (sel_idx < PORT_LIM))
                    state_nxt = ST_READ;
            end
            ST_READ: begin
                // Pop is held off while reset is asserted so the FIFO keeps the partial packet.
                pop  = glb_areset_n && !head_empty && oreg_free;
                last = head_eop || (word_cnt == CNT_LAST);
                for (int unsigned i = 0; i < PORT_NUM; i++)
                    fifo_rd_en[i] = pop && (cur_port == SEL_IDX_W'(i));
                if (pop && last)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (!glb_areset_n) begin
            state     <= ST_IDLE;
            cur_port  <= '0;
            word_cnt  <= '0;
            pkt_done  <= 1'b0;
            pkt_trunc <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pkt_done  <= pop && last;
            pkt_trunc <= pop && last && !head_eop;
            sel_err   <= (state == ST_IDLE) && sel_vld && (sel_idx >= PORT_LIM);
            if ((state == ST_IDLE) && (state_nxt == ST_READ)) begin
                cur_port <= sel_idx;
                word_cnt <= '0;
            end else if (pop) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    fifo_rd_oreg #(.DATA_W(DATA_W)) u_oreg (
        .glb_clk      (glb_clk),
        .glb_areset_n (glb_areset_n),
        .load         (pop),
        .load_data    (head_data),
        .load_eop     (last),
        .load_port    (cur_port),
        .free         (oreg_free),
        .ob           (ob)
    );

endmodule

// File: tb/tb_fifo_sel_rd.sv
// Directed bench for fifo_sel_rd with a show-ahead FIFO model per port and MAX_PKT_LEN = 4.
module tb_fifo_sel_rd;
    import fifo_sel_pkg::*;

    localparam int P     = 14;
    localparam int D     = 32;
    localparam int ML    = 4;
    localparam int DEPTH = 16;

    logic           glb_clk      = 1'b0;
    logic           glb_areset_n = 1'b0;
    logic [7:0]     code         = NON_FIFO_CHOOSE;
    logic [P-1:0]   fifo_empty, fifo_eop, fifo_rd_en;
    logic [P*D-1:0] fifo_dout;
    logic           pkt_done, pkt_trunc, sel_err;

    fifo_sel_rd_if #(.DATA_W(D)) bus ();

    fifo_sel_rd #(.PORT_NUM(P), .DATA_W(D), .MAX_PKT_LEN(ML)) dut (
        .glb_clk            (glb_clk),
        .glb_areset_n       (glb_areset_n),
        .fifo_sel_res_final (code),
        .fifo_empty         (fifo_empty),
        .fifo_dout          (fifo_dout),
        .fifo_eop           (fifo_eop),
        .fifo_rd_en         (fifo_rd_en),
        .ob                 (bus),
        .pkt_done           (pkt_done),
        .pkt_trunc          (pkt_trunc),
        .sel_err            (sel_err)
    );

    always #5 glb_clk = ~glb_clk;

    // Show-ahead FIFO model: {eop, data} per entry.
    logic [D:0]  mem [P][DEPTH];
    int unsigned wrp [P] = '{default: 0};
    int unsigned rdp [P] = '{default: 0};

    always_comb begin
        fifo_empty = '0;
        fifo_eop   = '0;
        fifo_dout  = '0;
        for (int i = 0; i < P; i++) begin
            fifo_empty[i]       = (wrp[i] == rdp[i]);
            fifo_eop[i]         = mem[i][rdp[i] % DEPTH][D];
            fifo_dout[i*D +: D] = mem[i][rdp[i] % DEPTH][D-1:0];
        end
    end

    always @(posedge glb_clk)
        for (int i = 0; i < P; i++)
            if (fifo_rd_en[i] && (wrp[i] != rdp[i]))
                rdp[i] <= rdp[i] + 1;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] got_data [64];
    logic         got_eop  [64];
    logic [6:0]   got_port [64];
    int ngot, n_done, n_trunc, n_err, n_bad;

    task automatic push(input int p, input logic [D-1:0] d, input logic e);
        mem[p][wrp[p] % DEPTH] = {e, d};
        wrp[p] = wrp[p] + 1;
    endtask

    function automatic int remaining(input int p);
        return int'(wrp[p] - rdp[p]);
    endfunction

    task automatic clear_log();
        ngot = 0; n_done = 0; n_trunc = 0; n_err = 0; n_bad = 0;
    endtask

    // One clock: log the handshake and protocol violations before the edge, pulses after it.
    task automatic cyc();
        #1;
        if (bus.out_valid && bus.out_ready && ngot < 64) begin
            got_data[ngot] = bus.out_data;
            got_eop[ngot]  = bus.out_eop;
            got_port[ngot] = bus.out_port;
            ngot++;
        end
        if ((fifo_rd_en & fifo_empty) != '0) n_bad++;
        if (!$onehot0(fifo_rd_en)) n_bad++;
        if (bus.out_valid && !bus.out_ready && fifo_rd_en != '0) n_bad++;
        @(posedge glb_clk);
        #1;
        if (pkt_done) n_done++;
        if (pkt_trunc) n_trunc++;
        if (pkt_trunc && !pkt_done) n_bad++;
        if (sel_err) n_err++;
    endtask

    task automatic drain(input int target, input logic [3:0] pat, input int maxc,
                         input logic [7:0] hold_code, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            bus.out_ready = pat[c % 4];
            cyc();
            code = (n_done >= target) ? NON_FIFO_CHOOSE : hold_code;
            if (n_done >= target && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        bus.out_ready = 1'b1;
        code = NON_FIFO_CHOOSE;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        glb_areset_n  = 1'b0;
        cyc(); cyc();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0 || bus.out_port !== 7'd0 || bus.out_eop !== 1'b0) begin
            errors++; $display("FAIL reset_oreg: got data %h port %0d eop %b expected 0/0/0", bus.out_data, bus.out_port, bus.out_eop); end
        checks++; if ({pkt_done, pkt_trunc, sel_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {pkt_done, pkt_trunc, sel_err}); end
        checks++; if (fifo_rd_en !== 14'h0) begin errors++; $display("FAIL reset_rd_en: got %h expected 0", fifo_rd_en); end
        glb_areset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        logic [D-1:0] exp_d;
        clear_log();
        for (int k = 0; k < 4; k++) push(3, 32'hA300_0000 + D'(k), k == 3);
        code = 8'd131;
        cyc();
        code = NON_FIFO_CHOOSE;
        checks++; if (fifo_rd_en !== 14'h0008 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_first_pop: got rd_en %h valid %b expected 0008/0", fifo_rd_en, bus.out_valid); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_d = 32'hA300_0000 + D'(k);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_port !== 7'd3 || bus.out_eop !== (k == 3)) begin
                errors++; $display("FAIL single_word%0d: got v%b %h p%0d e%b expected v1 %h p3 e%b",
                                   k, bus.out_valid, bus.out_data, bus.out_port, bus.out_eop, exp_d, k == 3); end
            checks++; if (pkt_done !== (k == 3) || pkt_trunc !== 1'b0) begin
                errors++; $display("FAIL single_done%0d: got done %b trunc %b expected %b/0", k, pkt_done, pkt_trunc, k == 3); end
            checks++; if (fifo_rd_en !== ((k < 3) ? 14'h0008 : 14'h0)) begin
                errors++; $display("FAIL single_rd_en%0d: got %h", k, fifo_rd_en); end
        end
        cyc();
        checks++; if (pkt_done !== 1'b0 || bus.out_valid !== 1'b0 || fifo_rd_en !== 14'h0) begin
            errors++; $display("FAIL single_after: got done %b valid %b rd_en %h expected 0/0/0", pkt_done, bus.out_valid, fifo_rd_en); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_backpressure();
        logic ok;
        clear_log();
        for (int k = 0; k < 4; k++) push(3, 32'hB300_0000 + D'(k), k == 3);
        code = 8'd131;
        drain(1, 4'b1001, 60, NON_FIFO_CHOOSE, ok);
        checks++; if (!ok || ngot !== 4) begin errors++; $display("FAIL bp_count: got ok %b words %0d expected 1/4", ok, ngot); end
        for (int k = 0; k < 4; k++) begin
            checks++; if ({got_port[k], got_eop[k], got_data[k]} !== {7'd3, k == 3, 32'hB300_0000 + D'(k)}) begin
                errors++; $display("FAIL bp_word%0d: got p%0d e%b %h expected p3 e%b %h",
                                   k, got_port[k], got_eop[k], got_data[k], k == 3, 32'hB300_0000 + D'(k)); end
        end
        checks++; if (n_bad !== 0 || n_done !== 1 || n_trunc !== 0 || remaining(3) !== 0) begin
            errors++; $display("FAIL bp_status: got bad %0d done %0d trunc %0d left %0d expected 0/1/0/0",
                               n_bad, n_done, n_trunc, remaining(3)); end
    endtask

    task automatic test_trunc();
        logic ok;
        clear_log();
        for (int k = 0; k < 6; k++) push(0, 32'hC000_0000 + D'(k), 1'b0);
        code = 8'h80;
        drain(1, 4'b1111, 60, NON_FIFO_CHOOSE, ok);
        checks++; if (!ok || ngot !== 4) begin errors++; $display("FAIL trunc_count: got ok %b words %0d expected 1/4", ok, ngot); end
        for (int k = 0; k < 4; k++) begin
            checks++; if ({got_port[k], got_eop[k], got_data[k]} !== {7'd0, k == 3, 32'hC000_0000 + D'(k)}) begin
                errors++; $display("FAIL trunc_word%0d: got p%0d e%b %h expected p0 e%b %h",
                                   k, got_port[k], got_eop[k], got_data[k], k == 3, 32'hC000_0000 + D'(k)); end
        end
        checks++; if (n_done !== 1 || n_trunc !== 1 || n_bad !== 0) begin
            errors++; $display("FAIL trunc_pulse: got done %0d trunc %0d bad %0d expected 1/1/0", n_done, n_trunc, n_bad); end
        checks++; if (remaining(0) !== 2) begin errors++; $display("FAIL trunc_left: got %0d expected 2", remaining(0)); end
    endtask

    task automatic test_bad_index();
        logic ok;
        clear_log();
        code = 8'd142;
        cyc();
        code = NON_FIFO_CHOOSE;
        checks++; if (sel_err !== 1'b1 || fifo_rd_en !== 14'h0) begin
            errors++; $display("FAIL bad_idx_err: got sel_err %b rd_en %h expected 1/0", sel_err, fifo_rd_en); end
        cyc();
        checks++; if (sel_err !== 1'b0 || fifo_rd_en !== 14'h0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bad_idx_after: got sel_err %b rd_en %h valid %b expected 0/0/0", sel_err, fifo_rd_en, bus.out_valid); end
        push(2, 32'hE200_0000, 1'b1);
        code = 8'd2;
        cyc(); cyc(); cyc();
        checks++; if (fifo_rd_en !== 14'h0 || bus.out_valid !== 1'b0 || remaining(2) !== 1) begin
            errors++; $display("FAIL no_valid_bit: got rd_en %h valid %b left %0d expected 0/0/1", fifo_rd_en, bus.out_valid, remaining(2)); end
        code = 8'd130;
        drain(1, 4'b1111, 30, NON_FIFO_CHOOSE, ok);
        checks++; if (!ok || ngot !== 1 || {got_port[0], got_eop[0], got_data[0]} !== {7'd2, 1'b1, 32'hE200_0000}) begin
            errors++; $display("FAIL bad_idx_recover: got ok %b words %0d p%0d %h expected 1/1 p2 e2000000", ok, ngot, got_port[0], got_data[0]); end
        checks++; if (n_err !== 1) begin errors++; $display("FAIL bad_idx_pulses: got %0d expected 1", n_err); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_log();
        for (int k = 0; k < 4; k++) push(3, 32'hD300_0000 + D'(k), k == 3);
        code = 8'd131;
        cyc();
        code = NON_FIFO_CHOOSE;
        cyc(); cyc();
        checks++; if (bus.out_data !== 32'hD300_0001) begin errors++; $display("FAIL rmid_second: got %h expected d3000001", bus.out_data); end
        glb_areset_n = 1'b0;
        #1;
        checks++; if (fifo_rd_en !== 14'h0) begin errors++; $display("FAIL rmid_rd_en: got %h expected 0", fifo_rd_en); end
        cyc();
        glb_areset_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_port !== 7'd0 || bus.out_eop !== 1'b0 || pkt_done !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs: got v%b %h p%0d e%b d%b expected all 0",
                               bus.out_valid, bus.out_data, bus.out_port, bus.out_eop, pkt_done); end
        checks++; if (remaining(3) !== 2) begin errors++; $display("FAIL rmid_left: got %0d expected 2", remaining(3)); end
        cyc();
        checks++; if (fifo_rd_en !== 14'h0) begin errors++; $display("FAIL rmid_idle: got rd_en %h expected 0", fifo_rd_en); end
        clear_log();
        code = 8'd131;
        drain(1, 4'b1111, 30, NON_FIFO_CHOOSE, ok);
        checks++; if (!ok || ngot !== 2) begin errors++; $display("FAIL rmid_resume_count: got ok %b words %0d expected 1/2", ok, ngot); end
        for (int k = 0; k < 2; k++) begin
            checks++; if ({got_port[k], got_eop[k], got_data[k]} !== {7'd3, k == 1, 32'hD300_0002 + D'(k)}) begin
                errors++; $display("FAIL rmid_resume%0d: got p%0d e%b %h expected p3 e%b %h",
                                   k, got_port[k], got_eop[k], got_data[k], k == 1, 32'hD300_0002 + D'(k)); end
        end
    endtask

    task automatic test_code_change();
        logic ok;
        logic [D-1:0] exp_d [5];
        logic [6:0]   exp_p [5];
        logic         exp_e [5];
        exp_d = '{32'hF300_0000, 32'hF300_0001, 32'hF300_0002, 32'hF500_0000, 32'hF500_0001};
        exp_p = '{7'd3, 7'd3, 7'd3, 7'd5, 7'd5};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        clear_log();
        for (int k = 0; k < 5; k++) push(int'(exp_p[k]), exp_d[k], exp_e[k]);
        code = 8'd131;
        drain(2, 4'b1111, 60, 8'd133, ok);
        checks++; if (!ok || ngot !== 5 || n_done !== 2) begin
            errors++; $display("FAIL chg_count: got ok %b words %0d done %0d expected 1/5/2", ok, ngot, n_done); end
        for (int k = 0; k < 5; k++) begin
            checks++; if ({got_port[k], got_eop[k], got_data[k]} !== {exp_p[k], exp_e[k], exp_d[k]}) begin
                errors++; $display("FAIL chg_word%0d: got p%0d e%b %h expected p%0d e%b %h",
                                   k, got_port[k], got_eop[k], got_data[k], exp_p[k], exp_e[k], exp_d[k]); end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL chg_protocol: got %0d violations expected 0", n_bad); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        clear_log();
        test_reset();
        test_single();
        test_backpressure();
        test_trunc();
        test_bad_index();
        test_reset_mid();
        test_code_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
